dccm_ctrl: RTL and testbench
============================

Name: dccm_ctrl

Overview:
- Data-closely-coupled-memory responder on the far end of the EXU/LSU DCCM port. It accepts one read request and one write request per cycle.
- It holds word storage and returns read data after a fixed, parameterised latency with a valid strobe.
- Sits beside exu at core top level, wired directly to the dccm_* ports.

Parameters:
- XLEN, 32, data/address width (taken from global package value)
- DCCM_BASE, 32'h0001_0000, byte base address of the DCCM window; must be DEPTH*4-aligned
- DCCM_DEPTH, 1024, number of XLEN-bit words; power of two
- RD_LAT, 1, cycles from dccm_rvalid_in to dccm_rvalid_out; legal 1..4

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- dccm_raddr  in  XLEN  read byte address
- dccm_rvalid_in  in  1  read request, one per cycle max
- dccm_rdata  out  XLEN  read data
- dccm_rvalid_out  out  1  read data valid, one-cycle pulse per request
- dccm_waddr  in  XLEN  write byte address
- dccm_wen  in  1  write enable
- dccm_wdata  in  XLEN  write data (full word)
- dccm_rd_err  out  1  out-of-window read flag, coincident with dccm_rvalid_out
- dccm_wr_err  out  1  registered pulse one cycle after an out-of-window write

Behaviour:
- Reset (asynchronous on rst_n low):
  - dccm_rvalid_out=0, dccm_rdata=0, dccm_rd_err=0, dccm_wr_err=0; all pipeline valids cleared.
  - Array contents are not reset.
  - In-flight reads at reset are dropped and never produce dccm_rvalid_out.
- Address decode:
  - in_range = (addr - DCCM_BASE) < DCCM_DEPTH*4, unsigned.
  - index = (addr - DCCM_BASE)[log2(DCCM_DEPTH)+1:2].
  - Address bits [1:0] are ignored; sub-word extraction belongs to the LSU.
- Write:
  - On the rising edge with dccm_wen=1 and in_range, mem[index] <= dccm_wdata.
  - An out-of-range write is dropped and dccm_wr_err pulses next cycle.
- Read issue:
  - On the rising edge with dccm_rvalid_in=1, stage 1 captures {valid=1, err=!in_range, data}.
  - data is 0 if out of range.
  - data is dccm_wdata if a write to the same index occurs in the same cycle (write-first forwarding).
  - Otherwise data is mem[index].
- Pipeline:
  - Stages 2..RD_LAT shift {valid, err, data} unconditionally; there is no stall input.
  - Read data is frozen at issue; later writes to the same word do not alter in-flight reads.
- Outputs:
  - dccm_rvalid_out is the last stage valid, so it asserts exactly RD_LAT cycles after the request.
  - dccm_rdata equals the last stage data when valid, else 0, so it is OR-mux safe.
  - dccm_rd_err equals last stage err AND valid.
- Throughput: back-to-back reads every cycle yield back-to-back valids in order. Reads and writes are fully concurrent.
- Simultaneous read and write to different indices: independent, no interaction.
- No backpressure: the requester must accept dccm_rvalid_out when presented.

Optional Feature:
- Macro: DCCM_PARITY_EN.
- With the macro defined:
  - Each word stores an extra even-parity bit computed from dccm_wdata.
  - Added input dccm_par_inject (1): when high with dccm_wen, the stored parity bit is inverted.
  - Added output dccm_par_err (1): on read, parity is recomputed at issue and carried through the pipeline. dccm_par_err asserts with dccm_rvalid_out on mismatch; data is still returned unchanged.
  - Forwarded reads (same-cycle write) use the forwarded parity, including the injected inversion.
  - Reset value of dccm_par_err is 0.
- Without the macro: no parity storage and neither port exists.

Decomposition:
- Shared package (types.svh/global.svh):
  - DCCM_BASE and DCCM_DEPTH defaults as localparams.
  - dccm_rd_stage_t struct {valid, err, par_err, data[XLEN-1:0]}.
- Sub-module dccm_sram: a plain 1R1W synchronous array with registered read and write-first same-cycle behaviour. It isolates the storage for later replacement by a foundry macro.
- dccm_ctrl keeps the address decode, the latency pipeline and error logic.

Test Plan:
- Write 0xDEADBEEF to 0x0001_0010, then read 0x0001_0010 -> dccm_rvalid_out high exactly RD_LAT cycles later with dccm_rdata=0xDEADBEEF and rd_err=0. Run at RD_LAT=1 and RD_LAT=4.
- Same-cycle write 0x12345678 and read of 0x0001_0020 (previously 0) -> read returns 0x12345678. A read one cycle before that write returns 0.
- Four back-to-back reads of 0x0001_0000/04/08/0C preloaded with 1/2/3/4 -> four consecutive valid cycles returning 1,2,3,4 in order. Between valids dccm_rdata=0.
- Read 0x0002_0000 with DEPTH=1024 (out of range) -> rvalid_out with rdata=0 and rd_err=1. Write 0x0000_FFFC -> wr_err pulses next cycle and no array word changes.
- Issue a read at RD_LAT=3, assert rst_n low one cycle later -> no dccm_rvalid_out ever appears for that request; all outputs are 0 during reset.
- DCCM_PARITY_EN: write 0xA5A5A5A5 to 0x0001_0040 with dccm_par_inject=1, then read it -> dccm_par_err=1 and rdata=0xA5A5A5A5. Rewrite without inject and read -> dccm_par_err=0.

Source files
------------

// File: rtl/dccm_ctrl_pkg.sv
// Shared types and defaults for the DCCM responder.
// The optional parity feature is built when DCCM_PARITY_EN is defined.
package dccm_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DccmBaseDefault = 32'h0001_0000;
  localparam int unsigned DccmDepthDefault = 1024;

  typedef struct packed {
    logic            valid;
    logic            err;
    logic            par_err;
    logic [XLEN-1:0] data;
  } dccm_rd_stage_t;

  // Even parity: the stored bit makes the XOR of data and parity zero.
  function automatic logic word_parity(input logic [XLEN-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/dccm_ctrl_if.sv
// DCCM request/response port bundle between the EXU/LSU and the DCCM responder.
// The parity inject/error signals exist only when DCCM_PARITY_EN is defined.
interface dccm_ctrl_if;
  import dccm_ctrl_pkg::*;

  logic [XLEN-1:0] dccm_raddr;
  logic            dccm_rvalid_in;
  logic [XLEN-1:0] dccm_rdata;
  logic            dccm_rvalid_out;
  logic [XLEN-1:0] dccm_waddr;
  logic            dccm_wen;
  logic [XLEN-1:0] dccm_wdata;
  logic            dccm_rd_err;
  logic            dccm_wr_err;
`ifdef DCCM_PARITY_EN
  logic            dccm_par_inject;
  logic            dccm_par_err;
`endif

  modport master (
    output dccm_raddr, dccm_rvalid_in, dccm_waddr, dccm_wen, dccm_wdata,
`ifdef DCCM_PARITY_EN
    output dccm_par_inject,
    input  dccm_par_err,
`endif
    input  dccm_rdata, dccm_rvalid_out, dccm_rd_err, dccm_wr_err
  );

  modport slave (
    input  dccm_raddr, dccm_rvalid_in, dccm_waddr, dccm_wen, dccm_wdata,
`ifdef DCCM_PARITY_EN
    input  dccm_par_inject,
    output dccm_par_err,
`endif
    output dccm_rdata, dccm_rvalid_out, dccm_rd_err, dccm_wr_err
  );

endinterface

// File: rtl/dccm_sram.sv
// Plain 1R1W synchronous word array with registered read and write-first forwarding.
// Kept separate so a foundry macro can replace it.
module dccm_sram #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dccm_ctrl.sv
// DCCM responder: address decode, fixed-latency read pipeline and error flags.
// Defining DCCM_PARITY_EN adds per-word even parity with inject and error report.
module dccm_ctrl
  import dccm_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] DCCM_BASE  = DccmBaseDefault,
  parameter int unsigned     DCCM_DEPTH = DccmDepthDefault,
  parameter int unsigned     RD_LAT     = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  dccm_ctrl_if.slave bus
);

  localparam int unsigned Aw = $clog2(DCCM_DEPTH);
  localparam logic [XLEN-1:0] WinBytes = XLEN'(DCCM_DEPTH * 4);

`ifdef DCCM_PARITY_EN
  localparam int unsigned MemW = XLEN + 1;
`else
  localparam int unsigned MemW = XLEN;
`endif

  logic [XLEN-1:0] roff, woff;
  logic            r_in, w_in;
  logic [Aw-1:0]   ridx, widx;
  logic [MemW-1:0] wword, rword;

  // Unsigned subtraction folds the lower and upper window bounds into one compare.
  assign roff = bus.dccm_raddr - DCCM_BASE;
  assign woff = bus.dccm_waddr - DCCM_BASE;
  assign r_in = roff < WinBytes;
  assign w_in = woff < WinBytes;
  assign ridx = roff[Aw+1:2];
  assign widx = woff[Aw+1:2];

`ifdef DCCM_PARITY_EN
  assign wword = {word_parity(bus.dccm_wdata) ^ bus.dccm_par_inject, bus.dccm_wdata};
`else
  assign wword = bus.dccm_wdata;
`endif

  dccm_sram #(
    .Width (MemW),
    .Depth (DCCM_DEPTH)
  ) u_sram (
    .clk_i   (clk),
    .we_i    (bus.dccm_wen & w_in),
    .waddr_i (widx),
    .wdata_i (wword),
    .re_i    (bus.dccm_rvalid_in & r_in),
    .raddr_i (ridx),
    .rdata_o (rword)
  );

  // Stage 1 data lives in the SRAM output register; only valid/err are held here.
  logic v1_q, v1_d, err1_q, err1_d, wr_err_q, wr_err_d;

  always_comb begin
    v1_d     = bus.dccm_rvalid_in;
    err1_d   = bus.dccm_rvalid_in & ~r_in;
    wr_err_d = bus.dccm_wen & ~w_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      err1_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      err1_q   <= err1_d;
      wr_err_q <= wr_err_d;
    end
  end

  dccm_rd_stage_t stage [RD_LAT];
  dccm_rd_stage_t stage0;

  always_comb begin
    stage0       = '0;
    stage0.valid = v1_q;
    stage0.err   = err1_q;
    stage0.data  = err1_q ? '0 : rword[XLEN-1:0];
`ifdef DCCM_PARITY_EN
    stage0.par_err = ~err1_q & (^rword);
`endif
  end

  assign stage[0] = stage0;

  for (genvar i = 1; i < RD_LAT; i++) begin : g_pipe
    dccm_rd_stage_t stage_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stage_q <= '0;
      else        stage_q <= stage[i-1];
    end
    assign stage[i] = stage_q;
  end

  dccm_rd_stage_t last;
  assign last = stage[RD_LAT-1];

  // Data is zeroed when not valid so several responders can be OR-combined.
  assign bus.dccm_rvalid_out = last.valid;
  assign bus.dccm_rdata      = last.valid ? last.data : '0;
  assign bus.dccm_rd_err     = last.valid & last.err;
  assign bus.dccm_wr_err     = wr_err_q;

`ifdef DCCM_PARITY_EN
  assign bus.dccm_par_err = last.valid & last.par_err;
`else
  logic unused_par;
  assign unused_par = last.par_err;
`endif

endmodule

// File: tb/tb_dccm_ctrl.sv
// Randomised bench for dccm_ctrl: three instances (RD_LAT 1, 3, 4) share one stimulus
// stream and are checked every cycle against a word-array model of the responder.
module tb_dccm_ctrl;
  import dccm_ctrl_pkg::*;

  localparam logic [31:0] Base  = 32'h0001_0000;
  localparam int          Depth = 1024;
  localparam int          MaxE  = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dccm_ctrl_if bus1 ();
  dccm_ctrl_if bus3 ();
  dccm_ctrl_if bus4 ();

  dccm_ctrl #(.DCCM_BASE(Base), .DCCM_DEPTH(Depth), .RD_LAT(1)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1));
  dccm_ctrl #(.DCCM_BASE(Base), .DCCM_DEPTH(Depth), .RD_LAT(3)) u_dut3 (
    .clk (clk), .rst_n (rst_n), .bus (bus3));
  dccm_ctrl #(.DCCM_BASE(Base), .DCCM_DEPTH(Depth), .RD_LAT(4)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .bus (bus4));

  logic p1, p3, p4;
`ifdef DCCM_PARITY_EN
  assign p1 = bus1.dccm_par_err;
  assign p3 = bus3.dccm_par_err;
  assign p4 = bus4.dccm_par_err;
`else
  assign p1 = 1'b0;
  assign p3 = 1'b0;
  assign p4 = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int ecount = 0;

  // Model: word array plus one result record per clock edge.
  bit [31:0] mem_m  [Depth];
  bit        par_m  [Depth];
  bit        rec_v  [MaxE];
  bit [31:0] rec_d  [MaxE];
  bit        rec_e  [MaxE];
  bit        rec_p  [MaxE];
  bit        werr_m [MaxE];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, ecount);
    end
  endtask

  function automatic bit in_win(input bit [31:0] a);
    bit [31:0] off;
    off = a - Base;
    return off < 32'(Depth * 4);
  endfunction

  function automatic int widx(input bit [31:0] a);
    bit [31:0] off;
    off = a - Base;
    return int'((off >> 2) & 32'(Depth - 1));
  endfunction

  task automatic cmp_port(input string nm, input int lat, input logic v, input logic [31:0] d,
                          input logic e, input logic p, input logic we_act);
    int  i;
    bit  ev, ee, ep;
    bit [31:0] ed;
    i  = ecount - lat + 1;
    ev = 0; ee = 0; ep = 0; ed = '0;
    if (rst_n && i >= 1 && rec_v[i]) begin
      ev = 1; ed = rec_d[i]; ee = rec_e[i]; ep = rec_p[i];
    end
    chk({nm, " rvalid_out"}, 32'(v), 32'(ev));
    chk({nm, " rdata"}, d, ed);
    chk({nm, " rd_err"}, 32'(e), 32'(ee));
    chk({nm, " wr_err"}, 32'(we_act), 32'(rst_n && werr_m[ecount]));
`ifdef DCCM_PARITY_EN
    chk({nm, " par_err"}, 32'(p), 32'(ep));
`else
    if (p !== 1'b0) chk({nm, " par_err idle"}, 32'(p), 32'd0);
`endif
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    cmp_port("L1", 1, bus1.dccm_rvalid_out, bus1.dccm_rdata, bus1.dccm_rd_err, p1,
             bus1.dccm_wr_err);
    cmp_port("L3", 3, bus3.dccm_rvalid_out, bus3.dccm_rdata, bus3.dccm_rd_err, p3,
             bus3.dccm_wr_err);
    cmp_port("L4", 4, bus4.dccm_rvalid_out, bus4.dccm_rdata, bus4.dccm_rd_err, p4,
             bus4.dccm_wr_err);
  end

  task automatic drive(input bit rv, input bit [31:0] ra, input bit we, input bit [31:0] wa,
                       input bit [31:0] wd, input bit inj);
    bus1.dccm_rvalid_in = rv; bus3.dccm_rvalid_in = rv; bus4.dccm_rvalid_in = rv;
    bus1.dccm_raddr = ra;     bus3.dccm_raddr = ra;     bus4.dccm_raddr = ra;
    bus1.dccm_wen = we;       bus3.dccm_wen = we;       bus4.dccm_wen = we;
    bus1.dccm_waddr = wa;     bus3.dccm_waddr = wa;     bus4.dccm_waddr = wa;
    bus1.dccm_wdata = wd;     bus3.dccm_wdata = wd;     bus4.dccm_wdata = wd;
`ifdef DCCM_PARITY_EN
    bus1.dccm_par_inject = inj; bus3.dccm_par_inject = inj; bus4.dccm_par_inject = inj;
`endif
  endtask

  // One clock: apply inputs, predict the effect of the coming edge, advance.
  task automatic step(input bit rv, input bit [31:0] ra, input bit we, input bit [31:0] wa,
                      input bit [31:0] wd, input bit inj);
    int e;
    bit inj_eff;
`ifdef DCCM_PARITY_EN
    inj_eff = inj;
`else
    inj_eff = 0;
`endif
    drive(rv, ra, we, wa, wd, inj);
    e = ecount + 1;
    rec_v[e] = 0; rec_d[e] = '0; rec_e[e] = 0; rec_p[e] = 0; werr_m[e] = 0;
    if (rst_n) begin
      werr_m[e] = we && !in_win(wa);
      if (rv) begin
        rec_v[e] = 1;
        if (!in_win(ra)) begin
          rec_e[e] = 1;
        end else if (we && in_win(wa) && widx(wa) == widx(ra)) begin
          rec_d[e] = wd;
          rec_p[e] = inj_eff;
        end else begin
          rec_d[e] = mem_m[widx(ra)];
          rec_p[e] = (^mem_m[widx(ra)]) ^ par_m[widx(ra)];
        end
      end
      if (we && in_win(wa)) begin
        mem_m[widx(wa)] = wd;
        par_m[widx(wa)] = (^wd) ^ inj_eff;
      end
    end
    @(posedge clk);
    ecount = e;
    #2;
  endtask

  task automatic idle();
    step(0, '0, 0, '0, '0, 0);
  endtask

  task automatic rd(input bit [31:0] a);
    step(1, a, 0, '0, '0, 0);
  endtask

  task automatic wr(input bit [31:0] a, input bit [31:0] d, input bit inj);
    step(0, '0, 1, a, d, inj);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i <= ecount; i++) rec_v[i] = 0;
    #1;
    chk("reset L3 rvalid_out", 32'(bus3.dccm_rvalid_out), 32'd0);
    chk("reset L4 rdata", bus4.dccm_rdata, 32'd0);
    repeat (n) idle();
    rst_n = 1'b1;
  endtask

  function automatic bit [31:0] rand_addr();
    int m;
    m = $urandom_range(0, 9);
    if (m == 0) return $urandom;
    if (m == 1) return Base + 32'h1000 + 32'($urandom_range(0, 15));
    if (m == 2) return Base - 32'd4 + 32'($urandom_range(0, 3));
    return Base + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    bit rv, we, inj;
    bit [31:0] ra, wa, wd;
    drive(0, '0, 0, '0, '0, 0);
    repeat (3) idle();
    #1;
    chk("reset L1 rvalid_out", 32'(bus1.dccm_rvalid_out), 32'd0);
    chk("reset L1 wr_err", 32'(bus1.dccm_wr_err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < Depth; i++) wr(Base + 32'(i * 4), 32'd0, 0);

    // Write then read, latency 1 and 4.
    wr(32'h0001_0010, 32'hDEAD_BEEF, 0);
    rd(32'h0001_0010);
    chk("lat1 rvalid", 32'(bus1.dccm_rvalid_out), 32'd1);
    chk("lat1 rdata", bus1.dccm_rdata, 32'hDEAD_BEEF);
    chk("lat1 rd_err", 32'(bus1.dccm_rd_err), 32'd0);
    idle();
    chk("lat1 pulse ends", 32'(bus1.dccm_rvalid_out), 32'd0);
    idle();
    chk("lat4 not early", 32'(bus4.dccm_rvalid_out), 32'd0);
    idle();
    chk("lat4 rvalid", 32'(bus4.dccm_rvalid_out), 32'd1);
    chk("lat4 rdata", bus4.dccm_rdata, 32'hDEAD_BEEF);

    // Read before the write sees the old word; same-cycle read gets forwarded data.
    rd(32'h0001_0020);
    chk("pre-write read", bus1.dccm_rdata, 32'd0);
    step(1, 32'h0001_0020, 1, 32'h0001_0020, 32'h1234_5678, 0);
    chk("forwarded read", bus1.dccm_rdata, 32'h1234_5678);

    // Back-to-back reads in order.
    for (int i = 0; i < 4; i++) wr(Base + 32'(i * 4), 32'(i + 1), 0);
    for (int i = 0; i < 4; i++) begin
      rd(Base + 32'(i * 4));
      chk("b2b rdata", bus1.dccm_rdata, 32'(i + 1));
    end
    idle();
    chk("b2b gap rdata", bus1.dccm_rdata, 32'd0);

    // Out-of-window read and write.
    rd(32'h0002_0000);
    chk("oow rvalid", 32'(bus1.dccm_rvalid_out), 32'd1);
    chk("oow rdata", bus1.dccm_rdata, 32'd0);
    chk("oow rd_err", 32'(bus1.dccm_rd_err), 32'd1);
    wr(32'h0000_FFFC, 32'hFFFF_FFFF, 0);
    chk("oow wr_err", 32'(bus1.dccm_wr_err), 32'd1);
    idle();
    chk("wr_err one cycle", 32'(bus1.dccm_wr_err), 32'd0);
    rd(32'h0001_0FFC);
    chk("top word untouched", bus1.dccm_rdata, 32'd0);
    rd(32'h0001_0000);
    chk("word0 untouched", bus1.dccm_rdata, 32'd1);

    // In-flight read killed by reset (latency 3).
    rd(32'h0001_0010);
    idle();
    do_reset(2);
    repeat (4) begin
      idle();
      chk("killed read L3", 32'(bus3.dccm_rvalid_out), 32'd0);
    end

`ifdef DCCM_PARITY_EN
    wr(32'h0001_0040, 32'hA5A5_A5A5, 1);
    rd(32'h0001_0040);
    chk("par inject err", 32'(bus1.dccm_par_err), 32'd1);
    chk("par inject data", bus1.dccm_rdata, 32'hA5A5_A5A5);
    wr(32'h0001_0040, 32'hA5A5_A5A5, 0);
    rd(32'h0001_0040);
    chk("par clean", 32'(bus1.dccm_par_err), 32'd0);
`endif

    for (int n = 0; n < 1500; n++) begin
      if (n % 400 == 399) do_reset(2);
      rv  = $urandom_range(0, 9) < 7;
      ra  = rand_addr();
      we  = $urandom_range(0, 9) < 6;
      wa  = ($urandom_range(0, 2) == 0) ? ra : rand_addr();
      wd  = $urandom;
      inj = $urandom_range(0, 4) == 0;
      step(rv, ra, we, wa, wd, inj);
    end
    repeat (6) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
